// File: rtl/ram_burst_master_if.sv
// Command, write-stream, read-stream and RAM-side signals of the burst master.
// The master modport is the block's own view; slave is the client/RAM view.
interface ram_burst_master_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
);
  logic              start;
  logic              op;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic              m_cen;
  logic              m_wen;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_din;
  logic [DATA_W-1:0] m_dout;

  modport master (
    input  start, op, base_addr, len, wr_data, wr_valid, m_dout,
    output wr_ready, rd_data, rd_valid, busy, done, m_cen, m_wen, m_addr, m_din
  );

  modport slave (
    output start, op, base_addr, len, wr_data, wr_valid, m_dout,
    input  wr_ready, rd_data, rd_valid, busy, done, m_cen, m_wen, m_addr, m_din
  );
endinterface

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port synchronous RAM: sequences cen/wen/addr
// for write or read bursts with wrapping addresses.
module ram_burst_master #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic                clk,
  input  logic                reset,
  ram_burst_master_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_W);

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remain;
  logic              op_r;
  logic              rd_valid_r;
  logic [LEN_W-1:0]  len_c;
  logic              access;

  assign len_c  = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
  assign access = (state == S_READ) || (state == S_WRITE && bus.wr_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cur_addr   <= '0;
      remain     <= '0;
      op_r       <= 1'b0;
      rd_valid_r <= 1'b0;
    end else begin
      // NOTE: rd_valid is delayed one cycle to match the RAM's read latency;
      // rd_data itself is a straight pass-through of m_dout.
      rd_valid_r <= (state == S_READ);
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_r     <= bus.op;
            cur_addr <= bus.base_addr;
            remain   <= len_c;
            if (len_c == '0)  state <= S_DONE;
            else if (bus.op)  state <= S_WRITE;
            else              state <= S_READ;
          end
        end
        S_WRITE: begin
          if (bus.wr_valid) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            remain   <= remain - LEN_W'(1);
            if (remain == LEN_W'(1)) state <= S_DONE;
          end
        end
        S_READ: begin
          cur_addr <= cur_addr + ADDR_W'(1);
          remain   <= remain - LEN_W'(1);
          if (remain == LEN_W'(1)) state <= S_DRAIN;
        end
        S_DRAIN: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM strobes follow the current state directly so a write lands in the
  // same cycle its data is accepted; idle strobes are forced to zero.
  assign bus.m_cen    = access;
  assign bus.m_wen    = access & op_r;
  assign bus.m_addr   = access ? cur_addr : '0;
  assign bus.m_din    = (access & op_r) ? bus.wr_data : '0;

  assign bus.wr_ready = (state == S_WRITE);
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.rd_valid = rd_valid_r;
  assign bus.rd_data  = bus.m_dout;

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: a RAM model, a cycle-indexed expectation model
// compared every cycle, and literal checks pinning key timings.
module tb_ram_burst_master;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        wr_ready;
    logic        cen;
    logic        wen;
    logic        rd_valid;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] rd_data;
  } exp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } drv_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ram_burst_master_if #(.ADDR_W(5), .DATA_W(32), .LEN_W(6)) bus ();

  ram_burst_master #(.ADDR_W(5), .DATA_W(32), .LEN_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous single-port RAM the block talks to.
  logic [31:0] ram [32];
  always @(posedge clk) begin
    if (bus.m_cen) begin
      if (bus.m_wen) ram[bus.m_addr] <= bus.m_din;
      else           bus.m_dout <= ram[bus.m_addr];
    end
  end

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic [31:0] shadow [32];
  logic [31:0] wdata  [32];
  exp_t exp_q [$];
  drv_t drv_q [$];

  int cyc = 0;
  int done_at = -1;
  int cen_cnt = 0;
  int rd_cnt = 0;
  logic [4:0]  addr_log [$];
  logic [31:0] rd_log   [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e = '0;
    return e;
  endfunction

  // Expected trace for one command, indexed by cycle since start (entry 0 is
  // the IDLE cycle in which start is sampled). Returns the done cycle.
  function automatic int build(input bit op_i, input int base_i, input int len_i,
                               input int stall_after, input int stall_n);
    exp_t e;
    drv_t d;
    int   lc, k, c, stalls;
    lc = (len_i > 32) ? 32 : len_i;
    exp_q.delete();
    drv_q.delete();
    d.valid = 1'b1;
    d.data  = $urandom;
    exp_q.push_back(idle_exp());
    drv_q.push_back(d);
    if (lc == 0) begin
      e = idle_exp();
      e.busy = 1'b1;
      e.done = 1'b1;
      exp_q.push_back(e);
      drv_q.push_back(d);
      return 1;
    end
    if (op_i) begin
      k = 0; c = 0; stalls = 0;
      while (k < lc) begin
        e = idle_exp();
        e.busy = 1'b1;
        e.wr_ready = 1'b1;
        d.valid = !(k == stall_after && stalls < stall_n);
        d.data  = d.valid ? wdata[k] : $urandom;
        if (d.valid) begin
          e.cen  = 1'b1;
          e.wen  = 1'b1;
          e.addr = 5'((base_i + k) % 32);
          e.din  = wdata[k];
          shadow[(base_i + k) % 32] = wdata[k];
          k++;
        end else begin
          stalls++;
        end
        c++;
        exp_q.push_back(e);
        drv_q.push_back(d);
      end
      e = idle_exp();
      e.busy = 1'b1;
      e.done = 1'b1;
      d.valid = 1'b1;
      d.data  = $urandom;
      exp_q.push_back(e);
      drv_q.push_back(d);
      return c + 1;
    end
    for (int cc = 1; cc <= lc + 2; cc++) begin
      e = idle_exp();
      e.busy = 1'b1;
      if (cc <= lc) begin
        e.cen  = 1'b1;
        e.addr = 5'((base_i + cc - 1) % 32);
      end
      if (cc >= 2 && cc <= lc + 1) begin
        e.rd_valid = 1'b1;
        e.rd_data  = shadow[(base_i + cc - 2) % 32];
      end
      e.done = (cc == lc + 2);
      d.valid = 1'b1;
      d.data  = $urandom;
      exp_q.push_back(e);
      drv_q.push_back(d);
    end
    return lc + 2;
  endfunction

  // Single compare process: one expectation record per cycle, idle otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_exp();
      check("busy",     32'(bus.busy),     32'(e.busy));
      check("done",     32'(bus.done),     32'(e.done));
      check("wr_ready", 32'(bus.wr_ready), 32'(e.wr_ready));
      check("m_cen",    32'(bus.m_cen),    32'(e.cen));
      check("m_wen",    32'(bus.m_wen),    32'(e.wen));
      check("m_addr",   32'(bus.m_addr),   32'(e.addr));
      check("m_din",    bus.m_din,         e.din);
      check("rd_valid", 32'(bus.rd_valid), 32'(e.rd_valid));
      if (e.rd_valid) check("rd_data", bus.rd_data, e.rd_data);
      if (bus.done === 1'b1) done_at = cyc;
      if (bus.m_cen === 1'b1) begin
        cen_cnt++;
        addr_log.push_back(bus.m_addr);
      end
      if (bus.rd_valid === 1'b1) begin
        rd_cnt++;
        rd_log.push_back(bus.rd_data);
      end
    end
  end

  // Called at posedge+#1 of cycle 0; returns at posedge+#1 of the cycle after done.
  task automatic run(input bit op_i, input int base_i, input int len_i,
                     input int stall_after, input int stall_n,
                     input int pulse_at, input int reset_at);
    int n;
    n = build(op_i, base_i, len_i, stall_after, stall_n);
    done_at = -1; cen_cnt = 0; rd_cnt = 0;
    addr_log.delete();
    rd_log.delete();
    for (int c = 0; c <= n; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      cyc = c;
      bus.start     = (c == 0) || (c == pulse_at);
      bus.op        = (c == 0) ? op_i : ~op_i;
      bus.base_addr = (c == 0) ? 5'(base_i) : 5'd17;
      bus.len       = (c == 0) ? 6'(len_i) : 6'd9;
      bus.wr_valid  = drv_q[c].valid;
      bus.wr_data   = drv_q[c].data;
      if (c == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        #1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.start = 1'b0;
        cyc = c + 1;
        return;
      end
    end
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.wr_valid = 1'b0;
    cyc = n + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      ram[i]    = 32'hDEAD_0000 | 32'(i);
      shadow[i] = 32'hDEAD_0000 | 32'(i);
    end
    bus.start = 1'b0; bus.op = 1'b0; bus.base_addr = '0; bus.len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.m_dout = '0;

    // Reset with random inputs, including a start that must be ignored.
    @(posedge clk); #1;
    chk_en = 1'b1;
    bus.start = 1'b1; bus.op = 1'b1; bus.base_addr = 5'($urandom);
    bus.len = 6'd5; bus.wr_valid = 1'b1; bus.wr_data = $urandom;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.start = 1'b0; bus.wr_valid = 1'b0;
    @(posedge clk); #1;

    // Full write then full read, base 0.
    for (int k = 0; k < 32; k++) wdata[k] = 32'(k);
    run(1'b1, 0, 32, -1, 0, -1, -1);
    check("wr32_done_cycle", 32'(done_at), 32'd33);
    check("wr32_accesses",   32'(cen_cnt), 32'd32);
    check("wr32_first_addr", 32'(addr_log[0]),  32'd0);
    check("wr32_last_addr",  32'(addr_log[31]), 32'd31);
    run(1'b0, 0, 32, -1, 0, -1, -1);
    check("rd32_done_cycle", 32'(done_at), 32'd34);
    check("rd32_words",      32'(rd_cnt),  32'd32);
    check("rd32_first_data", rd_log[0],  32'd0);
    check("rd32_last_data",  rd_log[31], 32'd31);

    // Wrap-around write and read.
    wdata[0] = 32'hA0A0_0001; wdata[1] = 32'hB0B0_0002;
    wdata[2] = 32'hC0C0_0003; wdata[3] = 32'hD0D0_0004;
    run(1'b1, 30, 4, -1, 0, -1, -1);
    check("wrap_addr0", 32'(addr_log[0]), 32'd30);
    check("wrap_addr1", 32'(addr_log[1]), 32'd31);
    check("wrap_addr2", 32'(addr_log[2]), 32'd0);
    check("wrap_addr3", 32'(addr_log[3]), 32'd1);
    check("wrap_wr_done_cycle", 32'(done_at), 32'd5);
    run(1'b0, 30, 4, -1, 0, -1, -1);
    check("wrap_rd0", rd_log[0], 32'hA0A0_0001);
    check("wrap_rd1", rd_log[1], 32'hB0B0_0002);
    check("wrap_rd2", rd_log[2], 32'hC0C0_0003);
    check("wrap_rd3", rd_log[3], 32'hD0D0_0004);
    check("wrap_rd_done_cycle", 32'(done_at), 32'd6);

    // Two stall cycles after the first word.
    wdata[0] = 32'h1111_0005; wdata[1] = 32'h2222_0006; wdata[2] = 32'h3333_0007;
    run(1'b1, 5, 3, 1, 2, -1, -1);
    check("stall_done_cycle", 32'(done_at), 32'd6);
    check("stall_accesses",   32'(cen_cnt), 32'd3);
    check("stall_addr0", 32'(addr_log[0]), 32'd5);
    check("stall_addr1", 32'(addr_log[1]), 32'd6);
    check("stall_addr2", 32'(addr_log[2]), 32'd7);

    // Zero-length commands.
    run(1'b1, 9, 0, -1, 0, -1, -1);
    check("len0_wr_done_cycle", 32'(done_at), 32'd1);
    check("len0_wr_accesses",   32'(cen_cnt), 32'd0);
    run(1'b0, 9, 0, -1, 0, -1, -1);
    check("len0_rd_done_cycle", 32'(done_at), 32'd1);
    check("len0_rd_accesses",   32'(cen_cnt), 32'd0);

    // Oversized length clamps to a full 32-word sweep.
    run(1'b0, 7, 40, -1, 0, -1, -1);
    check("len40_accesses",   32'(cen_cnt), 32'd32);
    check("len40_done_cycle", 32'(done_at), 32'd34);
    check("len40_wrap_addr",  32'(addr_log[25]), 32'd0);

    // Start pulsed while busy must not disturb the burst.
    for (int k = 0; k < 4; k++) wdata[k] = 32'h5500_0000 | 32'(k);
    run(1'b1, 12, 4, -1, 0, 2, -1);
    check("busy_start_accesses",   32'(cen_cnt), 32'd4);
    check("busy_start_done_cycle", 32'(done_at), 32'd5);

    // Reset in the middle of a read, then a normal read.
    run(1'b0, 0, 32, -1, 0, -1, 11);
    check("midrst_no_done",   32'(done_at), 32'hFFFF_FFFF);
    check("midrst_accesses",  32'(cen_cnt), 32'd11);
    check("midrst_rd_words",  32'(rd_cnt),  32'd10);
    run(1'b0, 20, 4, -1, 0, -1, -1);
    check("post_rst_done_cycle", 32'(done_at), 32'd6);
    check("post_rst_first",      rd_log[0], 32'd20);
    check("post_rst_last",       rd_log[3], 32'd23);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
